// File: rtl/cu_fsm_hs.sv
// cu_fsm_hs: multicycle OTTER control FSM (fetch / execute / mem-wait / writeback / interrupt / fault).
// Latency: ALU/branch 2 cycles, store 3, load 4 with zero-wait memory; +1 per not-ready cycle, +1 for a taken interrupt.
// Backpressure: mem_re1/mem_re2/mem_we stay asserted until imem_ready/dmem_ready; a watchdog faults a stuck access.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset (forces INIT)
//   opcode                        opcode of the instruction currently held in IR
//   imem_ready, dmem_ready        memory completion strobes
//   intr, mie                     level interrupt request and global enable
//   reset, pc_we, rf_we           datapath reset and write enables
//   mem_we, mem_re1, mem_re2      store / instruction-read / load requests
//   intr_taken, retire, bus_err   trap-entry pulse, retire pulse, sticky fault flag
module cu_fsm_hs #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4,
  parameter int INTR_EN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       intr,
  input  logic       mie,
  output logic       reset,
  output logic       pc_we,
  output logic       rf_we,
  output logic       mem_we,
  output logic       mem_re1,
  output logic       mem_re2,
  output logic       intr_taken,
  output logic       retire,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    FETCH = 3'd1,
    EX    = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    INTR  = 3'd5,
    FAULT = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Last tolerated wait count; the value is irrelevant when the watchdog is disabled.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          ps, ns;
  logic [TO_W-1:0] wait_cnt;

  logic is_load, is_store, is_branch;
  logic take_intr;
  logic expire;
  logic waiting;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  // Interrupt decision at an instruction boundary, sampled in the retiring cycle.
  assign take_intr = (INTR_EN != 0) && intr && mie;

  // Only consulted when the relevant ready is low, so ready always wins over expiry.
  assign expire  = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign waiting = ((ps == FETCH) && !imem_ready) || ((ps == MEM) && !dmem_ready);

  // Enables are decoded combinationally: EX-stage enables depend on the opcode
  // that only becomes valid in IR during that same cycle.
  always_comb begin
    ns         = ps;
    reset      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    mem_we     = 1'b0;
    mem_re1    = 1'b0;
    mem_re2    = 1'b0;
    intr_taken = 1'b0;
    retire     = 1'b0;
    bus_err    = 1'b0;
    case (ps)
      INIT: begin
        reset = 1'b1;
        ns    = FETCH;
      end
      FETCH: begin
        mem_re1 = 1'b1;
        if (imem_ready)  ns = EX;
        else if (expire) ns = FAULT;
      end
      EX: begin
        if (is_load) begin
          mem_re2 = 1'b1;
          ns      = MEM;
        end else if (is_store) begin
          mem_we = 1'b1;
          ns     = MEM;
        end else begin
          pc_we  = 1'b1;
          rf_we  = !is_branch;
          retire = 1'b1;
          ns     = take_intr ? INTR : FETCH;
        end
      end
      MEM: begin
        // Only loads and stores reach MEM; anything but a store is handled as a load.
        if (is_store) mem_we  = 1'b1;
        else          mem_re2 = 1'b1;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            ns     = take_intr ? INTR : FETCH;
          end else begin
            ns = WB;
          end
        end else if (expire) begin
          ns = FAULT;
        end
      end
      WB: begin
        pc_we  = 1'b1;
        rf_we  = 1'b1;
        retire = 1'b1;
        ns     = take_intr ? INTR : FETCH;
      end
      INTR: begin
        intr_taken = 1'b1;
        pc_we      = 1'b1;
        ns         = FETCH;
      end
      FAULT: begin
        bus_err = 1'b1;
      end
      default: begin
        ns = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps       <= INIT;
      wait_cnt <= '0;
    end else begin
      ps <= ns;
      if (ns != ps)    wait_cnt <= '0;
      else if (waiting) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cu_fsm_hs.sv
// tb_cu_fsm_hs: randomized self-checking bench for cu_fsm_hs.
// Expected outputs come from a per-instruction procedural model of the control sequence.
// A second instance exercises the disabled watchdog and disabled interrupts.
module tb_cu_fsm_hs;

  localparam int TMO = 15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  // Output vector order: reset,pc_we,rf_we,mem_we,mem_re1,mem_re2,intr_taken,retire,bus_err
  localparam logic [8:0] O_RST = 9'h100;
  localparam logic [8:0] O_PC  = 9'h080;
  localparam logic [8:0] O_RF  = 9'h040;
  localparam logic [8:0] O_WE  = 9'h020;
  localparam logic [8:0] O_RE1 = 9'h010;
  localparam logic [8:0] O_RE2 = 9'h008;
  localparam logic [8:0] O_IT  = 9'h004;
  localparam logic [8:0] O_RET = 9'h002;
  localparam logic [8:0] O_ERR = 9'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, intr, mie;
  logic       reset, pc_we, rf_we, mem_we, mem_re1, mem_re2, intr_taken, retire, bus_err;

  logic [6:0] op0;
  logic       imr0, dmr0, intr0, mie0;
  logic       reset0, pc_we0, rf_we0, mem_we0, mem_re10, mem_re20, intr_taken0, retire0, bus_err0;

  logic [8:0] outs, outs0;
  assign outs  = {reset, pc_we, rf_we, mem_we, mem_re1, mem_re2, intr_taken, retire, bus_err};
  assign outs0 = {reset0, pc_we0, rf_we0, mem_we0, mem_re10, mem_re20, intr_taken0, retire0, bus_err0};

  int vectors     = 0;
  int miscompares = 0;

  cu_fsm_hs #(.MEM_TIMEOUT(TMO), .TO_W(4), .INTR_EN(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .intr(intr), .mie(mie), .reset(reset), .pc_we(pc_we), .rf_we(rf_we), .mem_we(mem_we),
    .mem_re1(mem_re1), .mem_re2(mem_re2), .intr_taken(intr_taken), .retire(retire), .bus_err(bus_err)
  );

  cu_fsm_hs #(.MEM_TIMEOUT(0), .TO_W(4), .INTR_EN(0)) dut0 (
    .clk(clk), .rst(rst), .opcode(op0), .imem_ready(imr0), .dmem_ready(dmr0),
    .intr(intr0), .mie(mie0), .reset(reset0), .pc_we(pc_we0), .rf_we(rf_we0), .mem_we(mem_we0),
    .mem_re1(mem_re10), .mem_re2(mem_re20), .intr_taken(intr_taken0), .retire(retire0), .bus_err(bus_err0)
  );

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b exp=%b (reset,pc_we,rf_we,mem_we,re1,re2,intr_taken,retire,bus_err) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
  task automatic step(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check_eq(tag, outs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check_eq(tag, outs0, exp);
    @(posedge clk);
    #1;
  endtask

  // Interrupt lines only matter at a boundary; elsewhere they are random noise.
  task automatic noise();
    intr = 1'($urandom_range(0, 1));
    mie  = 1'($urandom_range(0, 1));
  endtask

  // One instruction: fw / mw are the not-ready cycles before imem_ready / dmem_ready.
  // irq / mie_v are the interrupt inputs seen in the retiring cycle.
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw,
                          input bit irq, input bit mie_v, output bit faulted);
    bit rdy;
    faulted = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      noise();
      opcode     = 7'($urandom);
      dmem_ready = 1'($urandom_range(0, 1));
      rdy        = (i >= fw);
      imem_ready = rdy;
      step("fetch", O_RE1);
      if (rdy) break;
      if (i == TMO - 1) begin
        faulted = 1'b1;
        return;
      end
    end
    opcode     = op;
    imem_ready = 1'($urandom_range(0, 1));
    if (op == OP_LOAD || op == OP_STORE) begin
      noise();
      dmem_ready = 1'($urandom_range(0, 1));
      step("ex_mem", (op == OP_LOAD) ? O_RE2 : O_WE);
      for (int i = 0; i < 1000; i++) begin
        noise();
        rdy        = (i >= mw);
        dmem_ready = rdy;
        if (op == OP_STORE && rdy) begin
          intr = irq;
          mie  = mie_v;
          step("mem_st_done", O_WE | O_PC | O_RET);
        end else begin
          step("mem_wait", (op == OP_STORE) ? O_WE : O_RE2);
        end
        if (rdy) break;
        if (i == TMO - 1) begin
          faulted = 1'b1;
          return;
        end
      end
      if (op == OP_LOAD) begin
        intr       = irq;
        mie        = mie_v;
        dmem_ready = 1'($urandom_range(0, 1));
        step("wb", O_PC | O_RF | O_RET);
      end
    end else begin
      intr       = irq;
      mie        = mie_v;
      dmem_ready = 1'($urandom_range(0, 1));
      step("ex_retire", (op == OP_BRANCH) ? (O_PC | O_RET) : (O_PC | O_RF | O_RET));
    end
    if (irq && mie_v) begin
      noise();
      opcode = 7'($urandom);
      step("intr", O_IT | O_PC);
    end
  endtask

  initial begin
    bit         flt;
    logic [6:0] op;
    int         fw, mw;

    rst = 1'b1; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0; intr = 1'b0; mie = 1'b0;
    op0 = '0; imr0 = 1'b0; dmr0 = 1'b0; intr0 = 1'b0; mie0 = 1'b0;

    // Reset held for 3 cycles, then one INIT cycle after release.
    repeat (3) step("rst_hold", O_RST);
    rst = 1'b0;
    step("init", O_RST);

    // Back-to-back ALU instructions with zero-wait fetch.
    repeat (10) do_instr(OP_ALU, 0, 0, 1'b0, 1'b0, flt);

    // Directed memory-latency and interrupt cases.
    do_instr(OP_LOAD, 0, 3, 1'b0, 1'b0, flt);
    do_instr(OP_STORE, 0, TMO - 1, 1'b0, 1'b0, flt);
    do_instr(OP_LOAD, TMO - 1, 0, 1'b0, 1'b0, flt);
    do_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1, flt);
    do_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0, flt);
    do_instr(OP_LOAD, 1, 2, 1'b1, 1'b1, flt);
    do_instr(OP_STORE, 2, 0, 1'b1, 1'b1, flt);

    // Store that never completes within the budget: FAULT, sticky until reset.
    do_instr(OP_STORE, 0, TMO, 1'b0, 1'b0, flt);
    repeat (6) begin
      noise();
      opcode     = 7'($urandom);
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      step("fault_hold", O_ERR);
    end
    rst = 1'b1;
    step("rst_fault", O_RST);
    rst = 1'b0;
    step("init_after_fault", O_RST);

    // Fetch that never completes: FAULT as well.
    do_instr(OP_ALU, TMO, 0, 1'b0, 1'b0, flt);
    noise();
    step("fault_fetch", O_ERR);
    rst = 1'b1;
    step("rst_fault2", O_RST);
    rst = 1'b0;
    step("init_after_fault2", O_RST);

    // Reset asserted in the middle of a MEM wait: the load request drops at once.
    intr = 1'b0; mie = 1'b0;
    imem_ready = 1'b1;
    step("fetch_pre_rst", O_RE1);
    opcode     = OP_LOAD;
    dmem_ready = 1'b0;
    step("ex_pre_rst", O_RE2);
    @(negedge clk);
    check_eq("mem_pre_rst", outs, O_RE2);
    #2 rst = 1'b1;
    #1 check_eq("mem_async_rst", outs, O_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("init_after_mid_rst", O_RST);

    // Randomized instruction stream.
    repeat (150) begin
      case ($urandom_range(0, 3))
        0: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_BRANCH;
        default: begin
          do op = 7'($urandom);
          while (op == OP_LOAD || op == OP_STORE || op == OP_BRANCH);
        end
      endcase
      fw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
      do_instr(op, fw, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), flt);
    end

    // Watchdog disabled and interrupts disabled on the second instance.
    rst = 1'b1;
    step0("rst0", O_RST);
    rst = 1'b0;
    step0("init0", O_RST);
    imr0 = 1'b0;
    repeat (100) step0("fetch_no_wdog", O_RE1);
    imr0 = 1'b1;
    step0("fetch0_done", O_RE1);
    op0 = OP_BRANCH; intr0 = 1'b1; mie0 = 1'b1; imr0 = 1'b0;
    step0("branch0_retire", O_PC | O_RET);
    step0("no_intr0", O_RE1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
